usb_frame_packer: RTL
=====================

Name: usb_frame_packer

Overview:
- Byte-stream framer between the FFT output buffer (byte FIFO, valid/rd interface) and the FTDI synchronous-FIFO writer.
- Wraps each FFT result frame in a fixed header (2 sync bytes, 16-bit frame counter) and a trailing XOR checksum, so the host can resynchronise after dropped bytes.
- Runs entirely in the 60 MHz USB clock domain.

Parameters:
- FRAME_BYTES, 4096: payload bytes per frame (FFT bins × 4 bytes: re/im, 16 bit each); must be ≥ 1.
- SYNC0, 8'hA5: first header byte.
- SYNC1, 8'h5A: second header byte.
- CSUM_EN, 1: 1 appends the checksum byte; 0 omits the CSUM state.

Ports:
- CLK  in  1  USB-domain clock (ftclk60).
- rstn  in  1  asynchronous reset, active-low.
- enable  in  1  permits new frames to start; sampled only in IDLE.
- in_data  in  8  payload byte from the output buffer.
- in_valid  in  1  in_data holds a valid byte.
- in_rd  out  1  one-cycle pop strobe to the output buffer.
- out_data  out  8  byte to the FTDI writer.
- out_valid  out  1  out_data holds a valid byte.
- out_rd  in  1  FTDI writer consumed out_data this cycle.
- busy  out  1  high whenever state ≠ IDLE.
- frame_cnt  out  16  counter value used for the current or next frame.

Behaviour:
- Reset (rstn low, async): state=IDLE, out_valid=0, out_data=0, in_rd=0, frame_cnt=0, payload index=0, checksum=0, busy=0.
- Output stage is one registered byte slot.
  - slot_free = !out_valid | out_rd.
  - A byte is loaded only when slot_free; out_valid falls only on out_rd with nothing loaded.
  - out_data must stay stable while out_valid & !out_rd.
- in_rd = (state==PAYLOAD) & in_valid & slot_free. The popped byte is loaded the same cycle.
  - Latency from in_valid to out_valid is 1 cycle.
  - in_rd is never asserted outside PAYLOAD.
- States and transitions (each non-IDLE state advances only on a load):
  - IDLE: go to SYNC0 when enable & in_valid. Nothing is loaded.
  - SYNC0: load SYNC0 → SYNC1.
  - SYNC1: load SYNC1 → CNT_HI.
  - CNT_HI: load frame_cnt[15:8]; csum = frame_cnt[15:8] → CNT_LO.
  - CNT_LO: load frame_cnt[7:0]; csum ^= byte → PAYLOAD; idx=0.
  - PAYLOAD: on each in_rd, load in_data, csum ^= in_data, idx++.
    - When idx==FRAME_BYTES-1 at the load, go to CSUM, or to END if CSUM_EN=0.
  - CSUM: load csum → END.
  - END: a zero-cycle bookkeeping step. frame_cnt increments in the same cycle as the last load (checksum, or final payload byte if CSUM_EN=0); state → IDLE.
- frame_cnt wraps 16'hFFFF → 16'h0000.
- Header and checksum bytes are generated internally and never wait on in_valid.
- Payload stall: if in_valid=0 in PAYLOAD, no byte is loaded and out_valid drops after the pending byte drains. No filler bytes, no state change.
- Downstream stall: out_rd=0 holds the slot and all state. No bytes are lost or duplicated.
- enable deasserted mid-frame: the frame completes normally, then the block stays in IDLE.
- Reset mid-frame: the partial frame is discarded, the output slot is cleared, and frame_cnt returns to 0.

Decomposition:
- Shared package (usb_frame_pkg) holds:
  - the state enum (IDLE, SYNC0, SYNC1, CNT_HI, CNT_LO, PAYLOAD, CSUM);
  - default sync constants;
  - the header length constant (4).
- Sub-module usb_byte_slot: the single-entry registered output stage. It has load/data in, out_valid/out_data/out_rd, and exports slot_free.
- Counter, FSM and checksum logic stay in the top.

Test Plan:
- FRAME_BYTES=4, enable=1, out_rd tied high, input 01 02 03 04 → out: A5 5A 00 00 01 02 03 04 04; frame_cnt=1 after.
- Same input again → A5 5A 00 01 01 02 03 04 05; frame_cnt=2.
- out_rd toggling 1-0-1-0 and in_valid gapped mid-payload → identical byte sequence; out_data stable during stalls; in_rd only when slot_free.
- Preload frame_cnt=FFFF (run 65535 frames or force) → header FF FF, checksum = FF^FF^payload XOR; next frame header 00 00.
- Assert rstn low after the third payload byte → out_valid=0 and busy=0 immediately; next frame starts with A5 5A 00 00.
- enable dropped during CNT_LO → current frame finishes with checksum; no new SYNC0 while enable=0, even with in_valid=1.

Source files
------------

// File: rtl/usb_frame_pkg.sv
// Shared types and constants for the USB frame packer: FSM state encoding,
// default sync bytes and the fixed header length.
package usb_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC0   = 3'd1,
        ST_SYNC1   = 3'd2,
        ST_CNT_HI  = 3'd3,
        ST_CNT_LO  = 3'd4,
        ST_PAYLOAD = 3'd5,
        ST_CSUM    = 3'd6
    } state_t;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

    // Sync bytes plus the big-endian 16-bit frame counter.
    localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/usb_byte_slot.sv
// Single-entry registered output stage. A byte is accepted only while the
// slot is free; valid drops only when the consumer reads with nothing new loaded.
module usb_byte_slot (
    input  logic       CLK,
    input  logic       rstn,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       out_rd_i,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    output logic       slot_free_o
);

    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    assign slot_free_o = !valid_q || out_rd_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i && slot_free_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (out_rd_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/usb_frame_packer.sv
// Frames FFT result bytes for the FTDI writer: two sync bytes, a 16-bit frame
// counter, FRAME_BYTES payload bytes and an optional XOR checksum.
module usb_frame_packer
    import usb_frame_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 4096,
    parameter logic [7:0]  SYNC0       = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1       = SYNC1_DEFAULT,
    parameter bit          CSUM_EN     = 1'b1
) (
    input  logic        CLK,
    input  logic        rstn,
    input  logic        enable,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_rd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_rd,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int unsigned IW = $clog2(FRAME_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    csum_q, csum_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          load;
    logic [7:0]    load_data;
    logic          slot_free;

    usb_byte_slot u_slot (
        .CLK         (CLK),
        .rstn        (rstn),
        .load_i      (load),
        .data_i      (load_data),
        .out_rd_i    (out_rd),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .slot_free_o (slot_free)
    );

    // Every non-idle state advances only on the cycle its byte enters the slot.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        idx_d     = idx_q;
        load      = 1'b0;
        load_data = 8'h00;
        in_rd     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && in_valid) begin
                    state_d = ST_SYNC0;
                end
            end
            ST_SYNC0: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = SYNC0;
                    state_d   = ST_SYNC1;
                end
            end
            ST_SYNC1: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = SYNC1;
                    state_d   = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = cnt_q[15:8];
                    csum_d    = cnt_q[15:8];
                    state_d   = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = cnt_q[7:0];
                    csum_d    = csum_q ^ cnt_q[7:0];
                    idx_d     = '0;
                    state_d   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (slot_free && in_valid) begin
                    in_rd     = 1'b1;
                    load      = 1'b1;
                    load_data = in_data;
                    csum_d    = csum_q ^ in_data;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        if (CSUM_EN) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = cnt_q + 16'd1;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (!CSUM_EN) begin
                    state_d = ST_IDLE;
                end else if (slot_free) begin
                    load      = 1'b1;
                    load_data = csum_q;
                    state_d   = ST_IDLE;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'h0000;
            csum_q  <= 8'h00;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign frame_cnt = cnt_q;

endmodule
